mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter N, default 32: data word width in bits.
REQ-002 Parameter L, default 16384: memory depth in words; the maximum loadable image size.
REQ-003 Parameter BASE_ADDR, default 0: byte address of the first word written.
REQ-004 Parameter TIMEOUT, default 1000000: maximum number of idle cycles allowed between bytes once a word is in progress.
REQ-005 clk  input  1  single system clock; all state updates on posedge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 byteValid  input  1  an incoming serial byte is present.
REQ-008 byteData  input  8  the incoming byte.
REQ-009 byteReady  output  1  the loader accepts a byte this cycle.
REQ-010 memoryWrite  output  1  one-cycle write strobe to the memory.
REQ-011 memoryRead  output  1  tied 0; the loader never reads.
REQ-012 memoryAddress  output  N  byte address of the write, always word-aligned.
REQ-013 memoryWriteData  output  N  assembled word.
REQ-014 cpuRst  output  1  active-low reset for the CPU; held 0 until the load completes successfully.
REQ-015 loadDone  output  1  image loaded; sticky.
REQ-016 loadError  output  1  load aborted; sticky.

Function
REQ-017 A byte transfers when byteValid && byteReady are both high at posedge clk; byteReady SHALL NOT depend combinationally on byteValid.
REQ-018 FSM states: S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR; the state after reset is S_LEN.
REQ-019 byteReady SHALL be 1 in S_LEN and S_DATA, and 0 in all other states.
REQ-020 Bytes are little-endian within a word (first byte -> bits [7:0], fourth byte -> bits [31:24]); a 2-bit byte counter tracks the position.
REQ-021 S_LEN: collect 4 bytes into the word count C. After the 4th byte: C==0 -> S_DONE; C>L -> S_ERR; otherwise load remaining=C and go to S_DATA.
REQ-022 S_DATA: collect 4 bytes into memoryWriteData. The cycle after the 4th byte transfers, go to S_WRITE.
REQ-023 S_WRITE: memoryWrite=1 for exactly one cycle, with memoryAddress and memoryWriteData stable. On exit: memoryAddress += 4 and remaining -= 1. If remaining becomes 0 -> S_DONE, else -> S_DATA.
REQ-024 Latency: the 4th data byte accepted at cycle t produces memoryWrite=1 at cycle t+1.
REQ-025 memoryWrite SHALL be 0 in every state except S_WRITE; memoryAddress SHALL only change on S_WRITE exit.
REQ-026 Idle counter: counts cycles with no transfer while in S_DATA, or in S_LEN with byte counter != 0. It clears on every transfer. Reaching TIMEOUT -> S_ERR. No timeout applies in S_LEN before the first byte.
REQ-027 S_DONE: loadDone=1, cpuRst=1, byteReady=0. The state is terminal until reset.
REQ-028 S_ERR: loadError=1, cpuRst=0, byteReady=0. The state is terminal until reset; no further memory writes occur.
REQ-029 loadDone and loadError SHALL never both be 1.
REQ-030 remaining counter is 15 bits wide, sufficient for L=16384; the comparison C>L uses the full 32-bit C.
REQ-031 A C of exactly L is legal; the last word is written to BASE_ADDR + 4*(L-1).

Reset
REQ-032 When rst=0, asynchronously: state=S_LEN, byte counter=0, idle counter=0, remaining=0, memoryAddress=BASE_ADDR, memoryWriteData=0, memoryWrite=0, memoryRead=0, byteReady=0, cpuRst=0, loadDone=0, loadError=0.
REQ-033 byteReady SHALL go to 1 on the first posedge after rst returns to 1.
REQ-034 Reset asserted mid-load SHALL abort the load: the partial word is discarded, no memoryWrite is issued, and the load restarts at S_LEN with memoryAddress=BASE_ADDR.

Verification
REQ-035 Send bytes 02 00 00 00, 78 56 34 12, EF BE AD DE back-to-back -> writes 0x12345678 at address 0 and 0xDEADBEEF at address 4, one memoryWrite pulse each; then loadDone=1 and cpuRst=1.
REQ-036 Send header 00 00 00 00 -> loadDone=1 with no memoryWrite pulse.
REQ-037 Send header 01 40 00 00 (C=16385) with L=16384 -> loadError=1, cpuRst stays 0, and byteReady=0 thereafter.
REQ-038 With TIMEOUT=8: header C=1, then 2 data bytes, then byteValid=0 for 8 cycles -> loadError=1 and no write occurs.
REQ-039 With byteValid toggled randomly, so that gaps are shorter than TIMEOUT, for C=3 -> same memory image as a back-to-back transfer; memoryAddress sequence is 0, 4, 8.
REQ-040 Assert rst for 1 cycle after the 2nd data byte of word 1, then replay a full C=1 image -> exactly one write, to address 0, with the new data.

Source files
------------

// File: rtl/mem_loader_if.sv
// mem_loader_if: byte-stream and memory-write bus of the image loader.
//   byteValid/byteData   : incoming serial byte (source -> loader)
//   byteReady            : loader accepts a byte this cycle
//   memoryWrite          : one-cycle write strobe
//   memoryRead           : read strobe (never used by the loader)
//   memoryAddress        : word-aligned byte address of the write
//   memoryWriteData      : assembled little-endian word
// Modports: master = loader side, slave = byte source / memory side.
interface mem_loader_if #(
   parameter int unsigned N = 32
);
   logic         byteValid;
   logic [7:0]   byteData;
   logic         byteReady;
   logic         memoryWrite;
   logic         memoryRead;
   logic [N-1:0] memoryAddress;
   logic [N-1:0] memoryWriteData;

   modport master (
      input  byteValid, byteData,
      output byteReady, memoryWrite, memoryRead, memoryAddress, memoryWriteData
   );

   modport slave (
      output byteValid, byteData,
      input  byteReady, memoryWrite, memoryRead, memoryAddress, memoryWriteData
   );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: receives a boot image as a byte stream (32-bit little-endian
// word count followed by that many little-endian data words) and writes it
// to memory starting at BASE_ADDR. Releases the CPU reset on success.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   bus       : byte stream in / memory write out (mem_loader_if.master)
//   cpuRst    : active-low CPU reset, released only after a good load
//   loadDone  : image loaded (sticky until reset)
//   loadError : load aborted by oversize count or byte timeout (sticky)
module mem_loader #(
   parameter int unsigned N         = 32,
   parameter int unsigned L         = 16384,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned TIMEOUT   = 1000000
) (
   input  logic         clk,
   input  logic         rst,
   mem_loader_if.master bus,
   output logic         cpuRst,
   output logic         loadDone,
   output logic         loadError
);
   localparam int unsigned RW = $clog2(L + 1);
   localparam int unsigned IW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;

   state_t        state, state_nx;
   logic [1:0]    bcnt, bcnt_nx;
   logic [IW-1:0] idle, idle_nx;
   logic [RW-1:0] remaining, remaining_nx;
   logic [31:0]   count, count_nx;
   logic [N-1:0]  addr, addr_nx;
   logic [N-1:0]  wdata, wdata_nx;
   logic          ready, ready_nx;
   logic          xfer;
   logic          counting;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_LEN;
         bcnt      <= '0;
         idle      <= '0;
         remaining <= '0;
         count     <= '0;
         addr      <= N'(BASE_ADDR);
         wdata     <= '0;
         ready     <= 1'b0;
      end else begin
         state     <= state_nx;
         bcnt      <= bcnt_nx;
         idle      <= idle_nx;
         remaining <= remaining_nx;
         count     <= count_nx;
         addr      <= addr_nx;
         wdata     <= wdata_nx;
         ready     <= ready_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      bcnt_nx      = bcnt;
      idle_nx      = idle;
      remaining_nx = remaining;
      count_nx     = count;
      addr_nx      = addr;
      wdata_nx     = wdata;

      xfer     = bus.byteValid && ready;
      counting = (state == S_DATA) || ((state == S_LEN) && (bcnt != 2'd0));

      // Idle watchdog; only armed once a word (or the count) is in progress.
      if (xfer) begin
         idle_nx = '0;
      end else if (counting) begin
         if (idle == IW'(TIMEOUT - 1)) state_nx = S_ERR;
         else                          idle_nx  = idle + 1'b1;
      end

      case (state)
         S_LEN: begin
            if (xfer) begin
               count_nx[{bcnt, 3'b000} +: 8] = bus.byteData;
               bcnt_nx = bcnt + 2'd1;
               if (bcnt == 2'd3) begin
                  if (count_nx == '0)     state_nx = S_DONE;
                  else if (count_nx > L)  state_nx = S_ERR;
                  else begin
                     remaining_nx = RW'(count_nx);
                     state_nx     = S_DATA;
                  end
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               wdata_nx[{bcnt, 3'b000} +: 8] = bus.byteData;
               bcnt_nx = bcnt + 2'd1;
               if (bcnt == 2'd3) state_nx = S_WRITE;
            end
         end
         S_WRITE: begin
            addr_nx      = addr + N'(4);
            remaining_nx = remaining - 1'b1;
            state_nx     = (remaining == RW'(1)) ? S_DONE : S_DATA;
         end
         default: ;
      endcase

      // Registered so it is low during reset and never follows byteValid.
      ready_nx = (state_nx == S_LEN) || (state_nx == S_DATA);
   end

   assign bus.byteReady       = ready;
   assign bus.memoryWrite     = (state == S_WRITE);
   assign bus.memoryRead      = 1'b0;
   assign bus.memoryAddress   = addr;
   assign bus.memoryWriteData = wdata;
   assign cpuRst              = (state == S_DONE);
   assign loadDone            = (state == S_DONE);
   assign loadError           = (state == S_ERR);
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed bench for mem_loader. Two instances: dut0 with the
// default depth (TIMEOUT=8) and dut1 with a tiny depth and non-zero base.
module tb_mem_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic       vld [2];
   logic [7:0] dat [2];
   logic cpu0, dn0, er0, cpu1, dn1, er1;

   int n_tests = 0;
   int n_fail  = 0;

   mem_loader_if #(.N(32)) b0 ();
   mem_loader_if #(.N(32)) b1 ();

   assign b0.byteValid = vld[0];
   assign b0.byteData  = dat[0];
   assign b1.byteValid = vld[1];
   assign b1.byteData  = dat[1];

   mem_loader #(.N(32), .L(16384), .BASE_ADDR(0), .TIMEOUT(8)) dut0 (
      .clk(clk), .rst(rst_n), .bus(b0.master),
      .cpuRst(cpu0), .loadDone(dn0), .loadError(er0)
   );

   mem_loader #(.N(32), .L(4), .BASE_ADDR(32'h100), .TIMEOUT(8)) dut1 (
      .clk(clk), .rst(rst_n), .bus(b1.master),
      .cpuRst(cpu1), .loadDone(dn1), .loadError(er1)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model (per instance k) ----------------
   int unsigned m_L    [2] = '{16384, 4};
   int unsigned m_base [2] = '{0, 32'h100};
   int unsigned m_to   [2] = '{8, 8};
   int unsigned m_nb   [2];   // bytes accepted since reset
   int unsigned m_idle [2];
   int unsigned m_nw   [2];   // words written
   bit          m_pend [2];   // a completed word is being written this cycle
   bit          m_done [2];
   bit          m_err  [2];
   bit          m_rdy  [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_hdr  [2];
   logic [31:0] m_word [2];

   logic [63:0] dq[$];   // writes seen on the DUT bus {addr, data}
   logic [63:0] mq[$];   // writes predicted by the model

   task automatic m_reset(input int k);
      m_nb[k] = 0; m_idle[k] = 0; m_nw[k] = 0;
      m_pend[k] = 0; m_done[k] = 0; m_err[k] = 0; m_rdy[k] = 0;
      m_addr[k] = m_base[k]; m_hdr[k] = 0; m_word[k] = 0;
   endtask

   task automatic m_step(input int k, input logic v, input logic [7:0] d);
      int unsigned pos;
      if (m_pend[k]) begin
         m_pend[k] = 0;
         m_nw[k]++;
         m_addr[k] = m_addr[k] + 4;
         if (m_nw[k] == m_hdr[k]) m_done[k] = 1;
      end else if (v && m_rdy[k]) begin
         m_idle[k] = 0;
         pos = m_nb[k] % 4;
         if (m_nb[k] < 4) m_hdr[k] = m_hdr[k] | (32'(d) << (8 * pos));
         else begin
            if (pos == 0) m_word[k] = 0;
            m_word[k] = m_word[k] | (32'(d) << (8 * pos));
         end
         m_nb[k]++;
         if (m_nb[k] == 4) begin
            if (m_hdr[k] == 0)            m_done[k] = 1;
            else if (m_hdr[k] > m_L[k])   m_err[k]  = 1;
         end else if (m_nb[k] > 4 && m_nb[k] % 4 == 0) m_pend[k] = 1;
      end else if (m_nb[k] > 0 && !m_done[k] && !m_err[k]) begin
         m_idle[k]++;
         if (m_idle[k] == m_to[k]) m_err[k] = 1;
      end
      m_rdy[k] = !m_done[k] && !m_err[k] && !m_pend[k];
   endtask

   always @(posedge clk or negedge rst_n)
      if (!rst_n) m_reset(0); else m_step(0, vld[0], dat[0]);
   always @(posedge clk or negedge rst_n)
      if (!rst_n) m_reset(1); else m_step(1, vld[1], dat[1]);

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cmp(input int k, input logic r, input logic w, input logic rd,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic c, input logic dn, input logic er);
      string s;
      s = $sformatf("dut%0d", k);
      chk({s, ".byteReady"},   64'(r),  64'(m_rdy[k]));
      chk({s, ".memoryWrite"}, 64'(w),  64'(m_pend[k]));
      chk({s, ".memoryRead"},  64'(rd), 64'(0));
      chk({s, ".memoryAddress"}, 64'(a), 64'(m_addr[k]));
      chk({s, ".cpuRst"},      64'(c),  64'(m_done[k]));
      chk({s, ".loadDone"},    64'(dn), 64'(m_done[k]));
      chk({s, ".loadError"},   64'(er), 64'(m_err[k]));
      if (m_pend[k]) begin
         chk({s, ".memoryWriteData"}, 64'(wd), 64'(m_word[k]));
         mq.push_back({m_addr[k], m_word[k]});
      end
      if (w === 1'b1) dq.push_back({a, wd});
   endtask

   always @(negedge clk) begin
      cmp(0, b0.byteReady, b0.memoryWrite, b0.memoryRead, b0.memoryAddress,
          b0.memoryWriteData, cpu0, dn0, er0);
      cmp(1, b1.byteReady, b1.memoryWrite, b1.memoryRead, b1.memoryAddress,
          b1.memoryWriteData, cpu1, dn1, er1);
   end

   // Compares both the DUT write log and the model write log to literals.
   task automatic expect_writes(input string nm, input int n, input logic [63:0] e [4]);
      chk({nm, "_dut_count"},   64'(dq.size()), 64'(n));
      chk({nm, "_model_count"}, 64'(mq.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (i < dq.size()) chk($sformatf("%s_dut_w%0d", nm, i),   dq[i], e[i]);
         if (i < mq.size()) chk($sformatf("%s_model_w%0d", nm, i), mq[i], e[i]);
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic do_reset();
      vld[0] = 0; vld[1] = 0; dat[0] = 0; dat[1] = 0;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      dq.delete(); mq.delete();
      rst_n = 1;
   endtask

   task automatic send_byte(input int k, input logic [7:0] d, input int gap);
      logic r;
      int   n;
      vld[k] = 0;
      repeat (gap) begin @(posedge clk); #1; end
      vld[k] = 1; dat[k] = d;
      n = 0;
      forever begin
         @(negedge clk);
         r = (k == 0) ? b0.byteReady : b1.byteReady;
         @(posedge clk); #1;
         if (r) break;
         n++;
         if (n > 50) begin
            n_tests++; n_fail++;
            $display("FAIL handshake_timeout: dut%0d byte %h not accepted", k, d);
            break;
         end
      end
      vld[k] = 0;
   endtask

   task automatic settle(input int c);
      repeat (c) begin @(posedge clk); #1; end
   endtask

   logic [63:0] e [4];
   logic [7:0]  img [$];

   initial begin
      vld[0] = 0; vld[1] = 0; dat[0] = 0; dat[1] = 0;
      settle(2);
      // reset values
      chk("rst_byteReady", 64'(b0.byteReady), 64'(0));
      chk("rst_address1",  64'(b1.memoryAddress), 64'(32'h100));
      rst_n = 1;
      @(posedge clk); #1;
      chk("ready_after_rst", 64'(b0.byteReady), 64'(1));

      // two-word image back-to-back
      do_reset();
      img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
              8'hEF, 8'hBE, 8'hAD, 8'hDE};
      foreach (img[i]) send_byte(0, img[i], 0);
      settle(4);
      e = '{{32'h0, 32'h12345678}, {32'h4, 32'hDEADBEEF}, 64'h0, 64'h0};
      expect_writes("two_words", 2, e);
      chk("two_words_done", 64'(dn0), 64'(1));
      chk("two_words_cpuRst", 64'(cpu0), 64'(1));

      // empty image
      do_reset();
      img = '{8'h00, 8'h00, 8'h00, 8'h00};
      foreach (img[i]) send_byte(0, img[i], 0);
      settle(3);
      e = '{64'h0, 64'h0, 64'h0, 64'h0};
      expect_writes("empty", 0, e);
      chk("empty_done", 64'(dn0), 64'(1));

      // oversize count: L+1
      do_reset();
      img = '{8'h01, 8'h40, 8'h00, 8'h00};
      foreach (img[i]) send_byte(0, img[i], 0);
      vld[0] = 1; dat[0] = 8'h55;
      settle(5);
      vld[0] = 0;
      chk("oversize_error", 64'(er0), 64'(1));
      chk("oversize_cpuRst", 64'(cpu0), 64'(0));
      chk("oversize_ready", 64'(b0.byteReady), 64'(0));

      // byte timeout inside a data word
      do_reset();
      img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
      foreach (img[i]) send_byte(0, img[i], 0);
      settle(7);
      chk("timeout_not_yet", 64'(er0), 64'(0));
      settle(1);
      chk("timeout_error", 64'(er0), 64'(1));
      settle(2);
      expect_writes("timeout", 0, e);

      // three words with random gaps shorter than TIMEOUT
      do_reset();
      img = '{8'h03, 8'h00, 8'h00, 8'h00};
      for (int i = 1; i <= 12; i++) img.push_back(8'(i));
      foreach (img[i]) send_byte(0, img[i], int'($urandom_range(0, 5)));
      settle(4);
      e = '{{32'h0, 32'h04030201}, {32'h4, 32'h08070605},
            {32'h8, 32'h0C0B0A09}, 64'h0};
      expect_writes("gappy", 3, e);
      chk("gappy_done", 64'(dn0), 64'(1));

      // reset in the middle of word 1, then a fresh one-word image
      do_reset();
      img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
      foreach (img[i]) send_byte(0, img[i], 0);
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
      foreach (img[i]) send_byte(0, img[i], 0);
      settle(4);
      e = '{{32'h0, 32'h11223344}, 64'h0, 64'h0, 64'h0};
      expect_writes("midreset", 1, e);
      chk("midreset_done", 64'(dn0), 64'(1));

      // count exactly L on the small instance, non-zero base
      do_reset();
      img = '{8'h04, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 16; i++) img.push_back(8'(8'h10 + i));
      foreach (img[i]) send_byte(1, img[i], 0);
      settle(4);
      e = '{{32'h100, 32'h13121110}, {32'h104, 32'h17161514},
            {32'h108, 32'h1B1A1918}, {32'h10C, 32'h1F1E1D1C}};
      expect_writes("full_depth", 4, e);
      chk("full_depth_done", 64'(dn1), 64'(1));

      // count L+1 on the small instance
      do_reset();
      img = '{8'h05, 8'h00, 8'h00, 8'h00};
      foreach (img[i]) send_byte(1, img[i], 0);
      settle(3);
      chk("small_oversize_error", 64'(er1), 64'(1));
      chk("small_oversize_done", 64'(dn1), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
